fpu_issue_queue: RTL
====================

Name: fpu_issue_queue

Overview:
- Parametrised request/response buffer that sits between the CPU-side FPU handshake and an FPU core such as FPU_VFloat_Wrapper.
- The CPU can enqueue up to DEPTH operations back-to-back instead of waiting for each result.
- Results return in order through a response FIFO with consumer back-pressure.
- Credits guarantee that no core result is ever dropped; the in-flight tag order is checked against the core's returned tags.

Parameters:
- EXP_WIDTH, 8, exponent bits; DATA_W = 1+EXP_WIDTH+MAN_WIDTH.
- MAN_WIDTH, 23, mantissa bits.
- DEPTH, 4, entries in the request FIFO and in the response FIFO; power of 2, at least 2.
- TAG_WIDTH, 4, tag bits.
- OP_WIDTH, 3, operator code bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  CPU request valid.
- fpu_ready  out  1  request FIFO can accept.
- operator  in  OP_WIDTH  operation code.
- rounding_mode  in  3  rounding mode.
- tag  in  TAG_WIDTH  request tag.
- inOp1, inOp2  in  DATA_W  operands.
- core_valid  out  1  request to core valid.
- core_ready  in  1  core accepts request.
- core_operator, core_rounding_mode, core_tag, core_op1, core_op2  out  matching widths  head request fields.
- core_result_valid  in  1  one-cycle core result pulse.
- core_tag_out  in  TAG_WIDTH  returned tag.
- core_result  in  DATA_W  returned result.
- core_exception  in  1  returned exception flag.
- result_valid  out  1  response FIFO head valid.
- cpu_ready  in  1  consumer accepts response.
- tag_out  out  TAG_WIDTH  response tag.
- result  out  DATA_W  response data.
- exception  out  1  response exception flag.
- inflight  out  $clog2(DEPTH)+1  requests issued to the core without a returned result.
- order_err  out  1  sticky tag-order/unexpected-result error.

Behaviour:
- Reset (reset=0): both FIFOs empty; inflight count and in-flight tag FIFO cleared.
  - Outputs: fpu_ready=0, core_valid=0, result_valid=0, order_err=0, inflight=0; data outputs 0.
  - First cycle after release: fpu_ready=1.
- Request FIFO (registered, show-ahead):
  - Push when in_valid && fpu_ready.
  - fpu_ready = !req_full. This is conservative: it stays 0 when full, even if a pop occurs in the same cycle.
  - A request accepted at edge T drives core_valid from T+1.
  - Fields are held stable while core_valid && !core_ready.
- Credit rule:
  - core_valid = !req_empty && (inflight + resp_count < DEPTH).
  - Issue when core_valid && core_ready: pop the request FIFO, push core_tag into the in-flight tag FIFO (depth DEPTH), inflight+1.
- Result capture:
  - On core_result_valid: push {core_tag_out, core_result, core_exception} into the response FIFO, pop the in-flight tag FIFO, inflight-1.
  - The push cannot overflow because of the credit rule.
  - Issue and result in the same cycle: inflight unchanged.
- Order checking:
  - If core_tag_out differs from the in-flight FIFO head, order_err is set and the result is still delivered.
  - If core_result_valid arrives with inflight=0, order_err is set and the result is discarded.
  - order_err clears only on reset.
- Response FIFO (show-ahead):
  - result_valid = !resp_empty.
  - Pop when result_valid && cpu_ready.
  - Outputs hold while stalled.
  - Result pulse at edge R is visible from R+1.
  - Push and pop in the same cycle are allowed at any occupancy, including full with pop.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full/empty from the MSB compare.
- Reset mid-operation: all queued and in-flight state is lost; the core shares the same reset.

Optional Feature:
- Macro: FPU_ISSUE_BYPASS_EN.
- Defined:
  - When the request FIFO is empty, inflight+resp_count<DEPTH, and in_valid && core_ready: the request goes combinationally to the core in the same cycle.
  - core_valid=1 and core_* fields come from the inputs; the request is not written into the FIFO.
  - Zero-cycle issue latency.
- Undefined:
  - Minimum one-cycle latency through the FIFO.
  - No combinational path from in_valid or the operands to core_*.

Test Plan:
- Single op: ADD 0x3f800000 + 0x40000000, tag 1; core returns 0x40400000 three cycles later.
  - core_valid one cycle after acceptance (zero cycles with FPU_ISSUE_BYPASS_EN).
  - result_valid one cycle after the core pulse; result=0x40400000, tag_out=1.
- Back-pressure full: core_ready=0, push tags 1..5 (DEPTH=4).
  - fpu_ready=0 after the 4th accept; the 5th is held until a slot frees.
  - Order 1..4 is preserved at core_tag.
- Credit stall: cpu_ready=0, core always ready, returning each result in 2 cycles, 8 requests.
  - Once inflight+resp_count reaches 4, core_valid drops.
  - No result is lost; after cpu_ready=1, tags come out in order 1..8.
- Exception passthrough: DIV 0x40000000 / 0x0, core returns 0x7f800000 with exception=1.
  - exception=1 and tag_out=D on the response.
- Order error: issue tags 2,3; core returns tag 3 first.
  - order_err=1 from the next cycle, sticky.
  - A stray core_result_valid with inflight=0 is discarded, and order_err stays 1.
- Reset mid-flight: reset low with 3 queued and 2 in-flight.
  - Immediately: all valids 0, inflight=0, order_err=0.
  - fpu_ready=1 one cycle after release.

Source files
------------

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
//   Request/response buffer between the CPU-side FPU handshake and an FPU
//   core. The CPU can queue up to DEPTH operations back-to-back. Issue to the
//   core is credit limited so that every core result always has a response
//   slot. Results return in order, and the tags the core returns are checked
//   against the order in which requests were issued.
//
//   Optional feature macro: FPU_ISSUE_BYPASS_EN
//     When defined, a request that arrives while the request FIFO is empty,
//     with credit available and core_ready high, is sent to the core
//     combinationally in the same cycle and is not written into the FIFO.
//     When undefined, every request passes through the FIFO. Issue then takes
//     at least one cycle, and there is no combinational path from the request
//     inputs to core_*.
//
// Ports
//   clk, reset              rising-edge clock; asynchronous active-low reset
//   in_valid / fpu_ready    CPU request handshake
//   operator, rounding_mode, tag, inOp1, inOp2   request fields
//   core_valid / core_ready request handshake to the core
//   core_operator, core_rounding_mode, core_tag, core_op1, core_op2
//                           head request fields
//   core_result_valid, core_tag_out, core_result, core_exception
//                           one-cycle result pulse from the core
//   result_valid / cpu_ready response handshake to the consumer
//   tag_out, result, exception   response head fields
//   inflight                requests issued to the core with no result yet
//   order_err               sticky tag-order / unexpected-result error
module fpu_issue_queue #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 4,
  parameter int OP_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          fpu_ready,
  input  logic [OP_WIDTH-1:0]           operator,
  input  logic [2:0]                    rounding_mode,
  input  logic [TAG_WIDTH-1:0]          tag,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]  inOp1,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]  inOp2,
  output logic                          core_valid,
  input  logic                          core_ready,
  output logic [OP_WIDTH-1:0]           core_operator,
  output logic [2:0]                    core_rounding_mode,
  output logic [TAG_WIDTH-1:0]          core_tag,
  output logic [EXP_WIDTH+MAN_WIDTH:0]  core_op1,
  output logic [EXP_WIDTH+MAN_WIDTH:0]  core_op2,
  input  logic                          core_result_valid,
  input  logic [TAG_WIDTH-1:0]          core_tag_out,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]  core_result,
  input  logic                          core_exception,
  output logic                          result_valid,
  input  logic                          cpu_ready,
  output logic [TAG_WIDTH-1:0]          tag_out,
  output logic [EXP_WIDTH+MAN_WIDTH:0]  result,
  output logic                          exception,
  output logic [$clog2(DEPTH):0]        inflight,
  output logic                          order_err
);

  localparam int DATA_W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int REQ_W  = OP_WIDTH + 3 + TAG_WIDTH + 2 * DATA_W;
  localparam int RESP_W = TAG_WIDTH + DATA_W + 1;
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

  // Request FIFO
  logic [REQ_W-1:0] req_mem [DEPTH];
  logic [AW:0]      req_wptr, req_rptr;
  logic [REQ_W-1:0] req_in, req_head, core_req;
  logic             req_full, req_empty, req_push, req_pop;

  // In-flight tag FIFO
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [AW:0]          tag_wptr, tag_rptr;
  logic [TAG_WIDTH-1:0] tag_head;

  // Response FIFO
  logic [RESP_W-1:0] resp_mem [DEPTH];
  logic [AW:0]       resp_wptr, resp_rptr, resp_count;
  logic              resp_empty, resp_pop;

  logic          init_q;
  logic [AW+1:0] used;
  logic          credit, bypass, issue, res_hit, res_stray, res_mis;

  assign req_in    = {operator, rounding_mode, tag, inOp1, inOp2};
  assign req_head  = req_mem[req_rptr[AW-1:0]];
  assign req_empty = (req_wptr == req_rptr);
  assign req_full  = (req_wptr[AW] != req_rptr[AW]) &&
                     (req_wptr[AW-1:0] == req_rptr[AW-1:0]);

  // init_q keeps fpu_ready low while reset is held and for the release cycle.
  assign fpu_ready = init_q && !req_full;

  assign inflight   = tag_wptr - tag_rptr;
  assign tag_head   = tag_mem[tag_rptr[AW-1:0]];
  assign resp_count = resp_wptr - resp_rptr;
  assign resp_empty = (resp_wptr == resp_rptr);

  // Results already owed plus results already buffered must leave room for
  // one more, so a core result can never find the response FIFO full.
  assign used   = {1'b0, inflight} + {1'b0, resp_count};
  assign credit = (used < DEPTH_V);

`ifdef FPU_ISSUE_BYPASS_EN
  assign bypass   = req_empty && credit && in_valid && fpu_ready && core_ready;
  assign core_req = bypass ? req_in : req_head;
`else
  assign bypass   = 1'b0;
  assign core_req = req_head;
`endif

  assign core_valid = bypass || (!req_empty && credit);
  assign {core_operator, core_rounding_mode, core_tag, core_op1, core_op2} = core_req;

  assign issue    = core_valid && core_ready;
  assign req_push = in_valid && fpu_ready && !bypass;
  assign req_pop  = issue && !bypass;

  assign res_hit   = core_result_valid && (inflight != '0);
  assign res_stray = core_result_valid && (inflight == '0);
  assign res_mis   = res_hit && (core_tag_out != tag_head);

  assign result_valid = !resp_empty;
  assign resp_pop     = result_valid && cpu_ready;
  assign {tag_out, result, exception} = resp_mem[resp_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_wptr <= '0;
      req_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) req_mem[i] <= '0;
    end else begin
      if (req_push) begin
        req_mem[req_wptr[AW-1:0]] <= req_in;
        req_wptr <= req_wptr + PTR_ONE;
      end
      if (req_pop) req_rptr <= req_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (issue) begin
        tag_mem[tag_wptr[AW-1:0]] <= core_tag;
        tag_wptr <= tag_wptr + PTR_ONE;
      end
      if (res_hit) tag_rptr <= tag_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_wptr <= '0;
      resp_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) resp_mem[i] <= '0;
    end else begin
      if (res_hit) begin
        resp_mem[resp_wptr[AW-1:0]] <= {core_tag_out, core_result, core_exception};
        resp_wptr <= resp_wptr + PTR_ONE;
      end
      if (resp_pop) resp_rptr <= resp_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      order_err <= 1'b0;
    end else if (res_mis || res_stray) begin
      order_err <= 1'b1;
    end
  end

endmodule
